// File: rtl/bounce_box.sv
// Bouncing square overlay: tracks the visible line, moves the box once per frame
// and emits a registered 12-bit RGB pixel for every pixel-enable cycle.
module bounce_box #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          BOX_SIZE  = 32,
  parameter int          STEP      = 2,
  parameter logic [11:0] BOX_COLOR = 12'hF80,
  parameter logic [11:0] BG_COLOR  = 12'h008
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_px_clk,
  input  logic       i_haddr_en,
  input  logic [9:0] i_hidx,
  input  logic       i_vaddr_en,
  input  logic       i_pause,
  output logic [3:0] o_vga_red,
  output logic [3:0] o_vga_green,
  output logic [3:0] o_vga_blue,
  output logic       o_frame_tick
);

  localparam logic [10:0] MAX_X  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] MAX_Y  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);
  localparam logic [9:0]  H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);

  logic [9:0]  v_idx_q, v_idx_d;
  logic        vaddr_q, vaddr_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [11:0] color_q, color_d;
  logic        frame_tick_s;
  logic        hit_s;

  // One axis step; returns {dir, pos}. 11-bit sums keep pos+STEP from wrapping.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                         input logic [10:0] max_pos);
    logic [10:0] sum;
    logic [10:0] res;
    sum = {1'b0, pos} + STEP_W;
    if (dir) begin
      if (sum >= max_pos) res = {1'b0, max_pos[9:0]};
      else                res = {1'b1, sum[9:0]};
    end else begin
      if ({1'b0, pos} <= STEP_W) res = {1'b1, 10'd0};
      else                       res = {1'b0, pos - STEP_W[9:0]};
    end
    return res;
  endfunction

  assign frame_tick_s = i_px_clk & vaddr_q & ~i_vaddr_en;

  assign hit_s = ({1'b0, i_hidx}  >= {1'b0, x_q}) && ({1'b0, i_hidx}  < ({1'b0, x_q} + BOX_W)) &&
                 ({1'b0, v_idx_q} >= {1'b0, y_q}) && ({1'b0, v_idx_q} < ({1'b0, y_q} + BOX_W));

  always_comb begin
    v_idx_d = v_idx_q;
    vaddr_d = vaddr_q;
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (i_px_clk) begin
      vaddr_d = i_vaddr_en;
      if (!i_vaddr_en) begin
        v_idx_d = 10'd0;
      end else if (i_haddr_en && (i_hidx == H_LAST) && (v_idx_q != V_LAST)) begin
        v_idx_d = v_idx_q + 10'd1;
      end else begin
        v_idx_d = v_idx_q;
      end
      if (i_haddr_en && i_vaddr_en) begin
        color_d = hit_s ? BOX_COLOR : BG_COLOR;
      end else begin
        color_d = 12'h000;
      end
    end else begin
      color_d = color_q;
    end
    // Motion only at the end of the visible frame, so a frame never tears.
    if (frame_tick_s && !i_pause) begin
      {dir_x_d, x_d} = bounce(x_q, dir_x_q, MAX_X);
      {dir_y_d, y_d} = bounce(y_q, dir_y_q, MAX_Y);
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      v_idx_q <= 10'd0;
      vaddr_q <= 1'b0;
      color_q <= 12'h000;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      v_idx_q <= v_idx_d;
      vaddr_q <= vaddr_d;
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign o_vga_red    = color_q[11:8];
  assign o_vga_green  = color_q[7:4];
  assign o_vga_blue   = color_q[3:0];
  assign o_frame_tick = frame_tick_s;

endmodule

// File: tb/tb_bounce_box.sv
// Scoreboard bench for bounce_box: a 640x480/STEP=2 instance and a 40x40/STEP=5
// instance share the timing inputs; expected pixels are queued, a monitor checks them.
module tb_bounce_box;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_px_clk = 1'b0;
  logic       i_haddr_en = 1'b0;
  logic [9:0] i_hidx = 10'd0;
  logic       i_vaddr_en = 1'b0;
  logic       i_pause_a = 1'b0;
  logic       i_pause_b = 1'b0;
  logic [3:0] ra, ga, ba, rb, gb, bb;
  logic       tick_a, tick_b;
  logic [11:0] col_a, col_b;

  assign col_a = {ra, ga, ba};
  assign col_b = {rb, gb, bb};

  bounce_box dut_a (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk), .i_haddr_en(i_haddr_en),
    .i_hidx(i_hidx), .i_vaddr_en(i_vaddr_en), .i_pause(i_pause_a),
    .o_vga_red(ra), .o_vga_green(ga), .o_vga_blue(ba), .o_frame_tick(tick_a));

  bounce_box #(.H_ACTIVE(40), .V_ACTIVE(40), .BOX_SIZE(32), .STEP(5)) dut_b (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk), .i_haddr_en(i_haddr_en),
    .i_hidx(i_hidx), .i_vaddr_en(i_vaddr_en), .i_pause(i_pause_b),
    .o_vga_red(rb), .o_vga_green(gb), .o_vga_blue(bb), .o_frame_tick(tick_b));

  always #5 clk = ~clk;

  localparam logic [11:0] BOX = 12'hF80;
  localparam logic [11:0] BG  = 12'h008;
  localparam logic [11:0] BLK = 12'h000;

  typedef struct {
    bit          chk;
    bit          sel;
    logic [11:0] col;
    logic        tick;
    string       name;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tick = 0;
  bit   sel_b = 1'b0;
  int   end_idx = 39;
  int   vact = 40;
  logic last_v = 1'b0;

  task automatic chk_col(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %03h expected %03h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One pixel-enable cycle followed by one idle cycle; expected response queued.
  task automatic pix(input logic v, input logic h, input int idx, input bit chk,
                     input logic [11:0] col, input string nm);
    ent_t e;
    @(posedge clk); #1;
    i_px_clk = 1'b1; i_vaddr_en = v; i_haddr_en = h; i_hidx = 10'(idx);
    e.chk = chk; e.sel = sel_b; e.col = col; e.tick = last_v & ~v; e.name = nm;
    q.push_back(e);
    last_v = v;
    @(posedge clk); #1;
    i_px_clk = 1'b0;
  endtask

  task automatic line_end();
    pix(1'b1, 1'b1, end_idx, 1'b0, BLK, "end");
  endtask

  task automatic qframe(input int n);
    for (int i = 0; i < n; i++) begin
      line_end();
      pix(1'b0, 1'b0, 0, 1'b0, BLK, "qfall");
    end
  endtask

  // Full frame probing the box edges at (px,py); pz is the pause level at the frame end.
  task automatic frame_probe(input int px, input int py, input string nm, input logic pz);
    int last;
    last = (py + 32 < vact) ? py + 32 : py + 31;
    for (int l = 0; l <= last; l++) begin
      if (l == 0) pix(1'b1, 1'b0, 5, 1'b1, BLK, {nm, " hblank"});
      if (l == py) begin
        if (px > 0) pix(1'b1, 1'b1, px - 1, 1'b1, BG, {nm, " left"});
        pix(1'b1, 1'b1, px, 1'b1, BOX, {nm, " x"});
        pix(1'b1, 1'b1, px + 31, 1'b1, BOX, {nm, " right"});
        if (px + 32 <= end_idx) pix(1'b1, 1'b1, px + 32, 1'b1, BG, {nm, " past"});
        if (px + 32 < end_idx) line_end();
      end else if (py > 0 && l == py - 1) begin
        pix(1'b1, 1'b1, px, 1'b1, BG, {nm, " above"});
        line_end();
      end else if (l == py + 31) begin
        pix(1'b1, 1'b1, px + 31, 1'b1, BOX, {nm, " corner"});
        if (px + 31 != end_idx) line_end();
      end else if (l == py + 32) begin
        pix(1'b1, 1'b1, px, 1'b1, BG, {nm, " below"});
        line_end();
      end else begin
        line_end();
      end
    end
    i_pause_a = pz;
    pix(1'b0, 1'b1, 3, 1'b1, BLK, {nm, " vblank"});
    pix(1'b0, 1'b0, 0, 1'b1, BLK, {nm, " blank"});
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk); #3;
    i_sclr = 1'b1;
    #1;
    chk_col({nm, " color"}, col_a, BLK);
    chk_int({nm, " tick"}, int'(tick_a), 0);
    i_vaddr_en = 1'b0; i_haddr_en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    i_sclr = 1'b0;
    last_v = 1'b0;
  endtask

  // Monitor: checks the previous pixel's color and this cycle's ticks on every pixel enable.
  ent_t pend;
  bit   have_pend = 1'b0;
  always @(negedge clk) begin
    ent_t e;
    if (i_px_clk) begin
      if (have_pend && pend.chk) chk_col(pend.name, pend.sel ? col_b : col_a, pend.col);
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: pixel cycle with no expected entry");
      end else begin
        e = q.pop_front();
        chk_int({e.name, " tick A"}, int'(tick_a), int'(e.tick));
        chk_int({e.name, " tick B"}, int'(tick_b), int'(e.tick));
        pend = e;
        have_pend = 1'b1;
      end
    end else begin
      chk_int("tick width", int'(tick_a | tick_b), 0);
    end
  end

  always @(posedge clk) if (tick_a) n_tick++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0;
    #7;
    chk_col("reset color", col_a, BLK);
    chk_int("reset tick", int'(tick_a), 0);
    repeat (2) @(posedge clk);
    #3 i_sclr = 1'b0;

    // Small instance, STEP=5, MAX=8: 0 -> 5 -> 8 -> 3 -> 0 -> 5
    sel_b = 1'b1; end_idx = 39; vact = 40;
    frame_probe(0, 0, "B start", 1'b1);
    qframe(2);
    frame_probe(3, 3, "B x3 down", 1'b1);
    frame_probe(0, 0, "B floor", 1'b1);
    frame_probe(5, 5, "B rebound", 1'b1);
    i_pause_b = 1'b1;

    sel_b = 1'b0; end_idx = 639; vact = 480; i_pause_a = 1'b0;
    do_reset("A reset");
    t0 = n_tick;
    frame_probe(0, 0, "A f1", 1'b0);
    qframe(2);
    chk_int("three ticks", n_tick - t0, 3);
    frame_probe(6, 6, "A f4", 1'b0);
    t0 = n_tick;
    frame_probe(8, 8, "A pause f5", 1'b1);
    qframe(2);
    frame_probe(8, 8, "A pause f8", 1'b1);
    chk_int("paused ticks", n_tick - t0, 4);
    frame_probe(8, 8, "A release", 1'b0);
    frame_probe(10, 10, "A resumed", 1'b0);
    qframe(297);
    frame_probe(606, 290, "A x606", 1'b0);
    frame_probe(608, 288, "A x608", 1'b0);
    frame_probe(606, 286, "A x606 back", 1'b0);

    for (int l = 0; l < 200; l++) line_end();
    pix(1'b1, 1'b1, 5, 1'b0, BLK, "line200");
    do_reset("midframe reset");
    pix(1'b0, 1'b0, 0, 1'b1, BLK, "post reset blank");
    pix(1'b0, 1'b1, 7, 1'b1, BLK, "post reset blank2");
    frame_probe(0, 0, "A restart", 1'b0);
    frame_probe(2, 2, "A restart moved", 1'b0);
    pix(1'b0, 1'b0, 0, 1'b0, BLK, "flush");
    @(posedge clk); #1;
    chk_int("queue drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bounce_box.md
BOUNCE_BOX -- requirements
Module: bounce_box

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 The block SHALL have parameter BOX_SIZE, default 32, square edge length in pixels.
REQ-004 The block SHALL have parameter STEP, default 2, pixels moved per axis per frame.
REQ-005 The block SHALL have parameter BOX_COLOR, default 12'hF80, box color as {R,G,B}.
REQ-006 The block SHALL have parameter BG_COLOR, default 12'h008, background color as {R,G,B}.
REQ-007 clk  input  1  system clock; the only clock in the block.
REQ-008 i_sclr  input  1  reset, asynchronous and active-high.
REQ-009 i_px_clk  input  1  pixel enable, one clk cycle wide; all state advances only when it is high.
REQ-010 i_haddr_en  input  1  horizontal visible-area flag.
REQ-011 i_hidx  input  10  horizontal pixel index, valid 0..H_ACTIVE-1 while i_haddr_en is high.
REQ-012 i_vaddr_en  input  1  vertical visible-area flag.
REQ-013 i_pause  input  1  freezes box motion while high.
REQ-014 o_vga_red, o_vga_green, o_vga_blue  output  4 each  registered pixel color.
REQ-015 o_frame_tick  output  1  one-clk pulse marking end of the visible frame.

Function
REQ-016 The block SHALL keep a 10-bit line counter v_idx, cleared on any i_px_clk cycle with i_vaddr_en low.
REQ-017 v_idx SHALL increment on an i_px_clk cycle with i_vaddr_en, i_haddr_en and i_hidx==H_ACTIVE-1 all high, and saturate at V_ACTIVE-1.
REQ-018 The block SHALL register i_vaddr_en on each i_px_clk cycle and assert o_frame_tick for exactly one clk when the registered value is 1 and the current value is 0.
REQ-019 Box position x (10 bits, 0..H_ACTIVE-BOX_SIZE), y (10 bits, 0..V_ACTIVE-BOX_SIZE), and direction bits dir_x, dir_y (1 = increasing) SHALL update only in the o_frame_tick cycle, and only if i_pause is low.
REQ-020 Each axis SHALL be updated independently. Moving up: if pos+STEP >= MAX, then pos becomes MAX and dir becomes 0; otherwise pos becomes pos+STEP. Moving down: if pos <= STEP, then pos becomes 0 and dir becomes 1; otherwise pos becomes pos-STEP.
REQ-021 Bounce arithmetic SHALL use at least 11-bit intermediates so that pos+STEP cannot wrap.
REQ-022 The box SHALL be hit when x <= i_hidx < x+BOX_SIZE and y <= v_idx < y+BOX_SIZE.
REQ-023 On each i_px_clk cycle, the color outputs SHALL be registered as follows: if i_haddr_en and i_vaddr_en are both high, the output is BOX_COLOR on a hit and BG_COLOR otherwise; in all other cases it is 12'h000.
REQ-024 Color latency SHALL be one i_px_clk cycle; outputs SHALL hold their value between i_px_clk pulses.
REQ-025 Position SHALL never change while i_vaddr_en is high, so no frame tears.
REQ-026 A rising edge of i_pause SHALL take effect at the next o_frame_tick; o_frame_tick SHALL keep pulsing while paused.

Reset
REQ-027 While i_sclr is high, immediately and regardless of clk: all color outputs 0, o_frame_tick 0, v_idx 0, x 0, y 0, dir_x 1, dir_y 1, and the registered vaddr_en 0.
REQ-028 A reset asserted mid-frame SHALL cause the first o_frame_tick after release only after a full visible period has been observed, because the registered vaddr_en restarts at 0.

Verification
REQ-029 Reset, then one frame at 640x480 with defaults -> pixel (0,0) is F80; (31,31) is F80; (32,0) is 008; blanking pixels are 000; output appears one i_px_clk after the index.
REQ-030 Run 3 frames -> o_frame_tick pulses 3 times, each one clk wide at the vaddr_en fall; box at x=6, y=6 in frame 4.
REQ-031 Preload near the edge (run until x=606, dir_x=1) -> next tick gives x=608 and dir_x=0; following tick gives x=606.
REQ-032 Set STEP=5, x=3 moving down -> next tick gives x=0 and dir_x=1; no underflow.
REQ-033 Hold i_pause high for 4 frames -> x and y unchanged and o_frame_tick still pulses 4 times; after release, motion resumes by STEP.
REQ-034 Assert i_sclr at line 200 of frame 2 -> outputs go to 0 asynchronously; after release, no o_frame_tick at the next vaddr_en fall unless a full visible period was seen; box restarts at (0,0).
